// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: round-robin arbiter that lets NUM_REQ requesters share one
// serial shift register of BIT_LEN bits.
//   clk, reset_n   : clock (rising edge) and synchronous active-low reset
//   req, req_data  : per-requester level request and payload slices
//   grant, ack     : one-hot owner of the transfer and its completion pulse
//   err            : completion-check failure, coincident with ack
//   busy, frame    : FSM not idle / transfer enable toward the sink
//   sr_data, sr_load, sr_shift, sr_complete : shift register handshake
module shift_arb_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BIT_LEN = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BIT_LEN-1:0] req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       err,
  output logic                       busy,
  output logic                       frame,
  output logic [BIT_LEN-1:0]         sr_data,
  output logic                       sr_load,
  output logic                       sr_shift,
  input  logic                       sr_complete
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    CHECK
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 frame_q, frame_d;
  logic [BIT_LEN-1:0]   sr_data_q, sr_data_d;
  logic                 sr_load_q, sr_load_d;
  logic                 sr_shift_q, sr_shift_d;
  int unsigned          winner;

  // First requester found searching upward from last+1, wrapping.
  function automatic int unsigned rr_pick(input logic [NUM_REQ-1:0] r,
                                          input int unsigned last);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (last + k) % NUM_REQ;
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    grant_d    = grant_q;
    sr_data_d  = sr_data_q;
    ack_d      = '0;
    err_d      = 1'b0;
    busy_d     = 1'b1;
    frame_d    = 1'b0;
    sr_load_d  = 1'b0;
    winner     = rr_pick(req, 32'(last_q));

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (|req) begin
          state_d   = LOAD;
          div_cnt_d = '0;
          last_d    = IDX_W'(winner);
          grant_d   = '0;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (winner == k) begin
              grant_d[k] = 1'b1;
              sr_data_d  = req_data[k*BIT_LEN +: BIT_LEN];
            end
          end
          busy_d    = 1'b1;
          frame_d   = 1'b1;
          sr_load_d = 1'b1;
        end
      end

      LOAD: begin
        frame_d = 1'b1;
        if (div_cnt_q == DIV_LAST) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = BIT_W'(BIT_LEN - 1);
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
          sr_load_d = 1'b1;
        end
      end

      SHIFT: begin
        frame_d = 1'b1;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == '0) begin
            state_d = CHECK;
            frame_d = 1'b0;
            ack_d   = grant_q;
            err_d   = ~sr_complete;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      CHECK: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Strobe derived from the next-cycle counter so the registered output
    // lines up with the divider phase it belongs to.
    sr_shift_d = frame_d && (div_cnt_d >= DIV_HALF);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      frame_q    <= 1'b0;
      sr_data_q  <= '0;
      sr_load_q  <= 1'b0;
      sr_shift_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      frame_q    <= frame_d;
      sr_data_q  <= sr_data_d;
      sr_load_q  <= sr_load_d;
      sr_shift_q <= sr_shift_d;
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign frame    = frame_q;
  assign sr_data  = sr_data_q;
  assign sr_load  = sr_load_q;
  assign sr_shift = sr_shift_q;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Testbench for shift_arb_ctrl: directed table, multi-cycle corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_shift_arb_ctrl;

  localparam int NR = 4;
  localparam int BL = 8;
  localparam int CD = 4;
  localparam int T  = CD * (BL + 1);   // cycles from grant to ack

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*BL-1:0]  req_data = '0;
  logic              fault = 1'b0;
  logic [NR-1:0]     grant, ack;
  logic              err, busy, frame, sr_load, sr_shift, sr_complete;
  logic [BL-1:0]     sr_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_arb_ctrl #(.NUM_REQ(NR), .BIT_LEN(BL), .CLK_DIV(CD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .err(err), .busy(busy), .frame(frame),
    .sr_data(sr_data), .sr_load(sr_load), .sr_shift(sr_shift),
    .sr_complete(sr_complete)
  );

  // Sink shift register: loads on a strobe edge while sr_load, otherwise
  // shifts MSB first and records the serial output.
  logic [BL-1:0] sreg = '0;
  logic [BL-1:0] sink_out = '0;
  int            nsh = 0;

  always @(posedge sr_shift) begin
    if (sr_load) begin
      sreg <= sr_data;
      nsh  <= 0;
    end else begin
      sink_out <= {sink_out[BL-2:0], sreg[BL-1]};
      sreg     <= {sreg[BL-2:0], 1'b0};
      nsh      <= nsh + 1;
    end
  end

  assign sr_complete = (nsh == BL) && !fault;

  // Reference model: a transfer is "active" for T+1 cycles counted by m_t;
  // outputs are derived arithmetically from m_t.
  function automatic int rr(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return last;
  endfunction

  function automatic logic [BL-1:0] slice(input logic [NR*BL-1:0] d, input int i);
    return d[i*BL +: BL];
  endfunction

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  logic          m_active = 1'b0;
  int            m_t = 0;
  int            m_owner = 0;
  int            m_last = NR - 1;
  logic [BL-1:0] m_data = '0;
  logic          m_fault = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_last   <= NR - 1;
      m_data   <= '0;
    end else if (!m_active) begin
      if (req != '0) begin
        m_owner  <= rr(req, m_last);
        m_last   <= rr(req, m_last);
        m_data   <= slice(req_data, rr(req, m_last));
        m_active <= 1'b1;
        m_t      <= 0;
      end
    end else if (m_t == T) begin
      m_active <= 1'b0;
    end else begin
      if (m_t == T - 1) m_fault <= fault;
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, got none expected event at %0t", name, $time);
  endtask

  task automatic model_check();
    logic [NR-1:0] eg, ea;
    logic          ee, eb, ef, el, es;
    eg = m_active ? oh(m_owner) : '0;
    ea = (m_active && m_t == T) ? oh(m_owner) : '0;
    ee = m_active && m_t == T && m_fault;
    eb = m_active;
    ef = m_active && m_t < T;
    el = m_active && m_t < CD;
    es = m_active && m_t < T && (m_t % CD) >= CD / 2;
    chk("model_cycle", {grant, ack, err, busy, frame, sr_load, sr_shift, sr_data},
        {eg, ea, ee, eb, ef, el, es, m_data});
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 2 * T; n++) begin
      if (!busy) return;
      tick();
    end
    bound_fail("wait_idle");
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic          fault;
    int            exp_idx;
    logic          exp_err;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit            ok;
    int            nload, rises, lat;
    logic          prev_sh, ack_seen;
    logic [NR-1:0] prev_g;
    logic [NR-1:0] exp_order[5];
    int            gcount, last_gt, cyc;
    logic [BL-1:0] payload;

    vt[0] = '{req: 4'b0001, fault: 1'b0, exp_idx: 0, exp_err: 1'b0};
    vt[1] = '{req: 4'b0101, fault: 1'b0, exp_idx: 2, exp_err: 1'b0};
    vt[2] = '{req: 4'b0101, fault: 1'b0, exp_idx: 0, exp_err: 1'b0};
    vt[3] = '{req: 4'b1000, fault: 1'b1, exp_idx: 3, exp_err: 1'b1};
    vt[4] = '{req: 4'b0110, fault: 1'b0, exp_idx: 1, exp_err: 1'b0};
    vt[5] = '{req: 4'b1111, fault: 1'b0, exp_idx: 2, exp_err: 1'b0};

    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {grant, ack, err, busy, frame, sr_load, sr_shift, sr_data}, '0);
    reset_n = 1'b1;
    tick();

    // Directed table: arbitration order, payload, timing, withdrawal, fault.
    for (int i = 0; i < 6; i++) begin
      req_data = {$urandom};
      if (i == 0) req_data[7:0] = 8'hA5;
      payload = slice(req_data, vt[i].exp_idx);
      req   = vt[i].req;
      fault = vt[i].fault;
      wait_grant(ok);
      if (!ok) bound_fail("tbl_grant");
      chk("tbl_grant", grant, oh(vt[i].exp_idx));
      chk("tbl_sr_data", sr_data, payload);
      nload = 0; rises = 0; lat = 0; prev_sh = 1'b0; ok = 1'b0;
      for (int n = 0; n < T + 10; n++) begin
        if (sr_load) nload++;
        if (sr_shift && !prev_sh) rises++;
        prev_sh = sr_shift;
        if (ack != '0) begin
          ok = 1'b1;
          break;
        end
        tick();
        lat++;
        if (lat == 2) begin
          req      = '0;
          req_data = {$urandom};
        end
      end
      if (!ok) bound_fail("tbl_ack");
      chk("tbl_ack_latency", 64'(lat), 64'(T));
      chk("tbl_ack", ack, oh(vt[i].exp_idx));
      chk("tbl_err", err, vt[i].exp_err);
      chk("tbl_load_cycles", 64'(nload), 64'(CD));
      chk("tbl_shift_edges", 64'(rises), 64'(BL + 1));
      chk("tbl_sink_bits", sink_out, payload);
      tick();
      chk("tbl_idle_after", {busy, frame, grant, ack}, '0);
      fault = 1'b0;
    end

    // Contention: all four held continuously from reset.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    req_data = {$urandom};
    prev_g = '0; gcount = 0; last_gt = 0;
    for (cyc = 0; cyc < 6 * (T + 2) && gcount < 5; cyc++) begin
      tick();
      if (prev_g == '0 && grant != '0) begin
        chk("cont_grant", grant, exp_order[gcount]);
        if (gcount > 0) chk("cont_spacing", 64'(cyc - last_gt), 64'(T + 2));
        last_gt = cyc;
        gcount++;
      end
      prev_g = grant;
    end
    if (gcount < 5) bound_fail("cont_grants");
    req = '0;
    wait_idle();
    tick();

    // Reset in the middle of SHIFT (bit counter at 4): abort with no ack.
    req = 4'b0001;
    req_data = {$urandom};
    wait_grant(ok);
    if (!ok) bound_fail("rst_grant");
    repeat (4 * CD + 1) tick();
    reset_n = 1'b0;
    req = '0;
    tick();
    chk("rst_outputs", {grant, ack, err, busy, frame, sr_load, sr_shift, sr_data}, '0);
    reset_n = 1'b1;
    ack_seen = 1'b0;
    repeat (T + 4) begin
      tick();
      if (ack != '0) ack_seen = 1'b1;
    end
    chk("rst_no_ack", ack_seen, 1'b0);
    req = 4'b0010;
    req_data = {$urandom};
    payload = slice(req_data, 1);
    wait_grant(ok);
    if (!ok) bound_fail("rst_regrant");
    chk("rst_regrant", grant, 4'b0010);
    req = '0;
    ok = 1'b0;
    for (int n = 0; n < T + 10; n++) begin
      tick();
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("rst_ack");
    chk("rst_reload_bits", sink_out, payload);
    chk("rst_err", err, 1'b0);
    tick();

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = NR'($urandom);
      if ($urandom_range(0, 3) == 0) req_data = {$urandom};
      if ($urandom_range(0, 15) == 0) fault = ~fault;
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_arb_ctrl.md
SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one serial shift register.
REQ-002 Parameter BIT_LEN, default 8: bits per transfer; shall match the shift register width.
REQ-003 Parameter CLK_DIV, default 4: clk cycles per strobe period; even, >= 2.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 req  in  NUM_REQ  per-requester transfer request, level.
REQ-007 req_data  in  NUM_REQ*BIT_LEN  request payloads; slice i is [i*BIT_LEN +: BIT_LEN].
REQ-008 grant  out  NUM_REQ  one-hot owner of the current transfer; zero when idle.
REQ-009 ack  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-010 err  out  1  one-cycle pulse, coincident with ack, when the completion check fails.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 frame  out  1  high during LOAD and SHIFT; serves as the transfer enable toward the sink.
REQ-013 sr_data  out  BIT_LEN  payload driven to the shift register data bus.
REQ-014 sr_load  out  1  shift register load request.
REQ-015 sr_shift  out  1  shift register strobe; the register acts on its rising edge.
REQ-016 sr_complete  in  1  shift-complete flag returned by the shift register.

Function
REQ-017 FSM states are IDLE, LOAD, SHIFT and CHECK; all outputs shall be registered.
REQ-018 IDLE: if req != 0, the FSM shall select a winner by round-robin, searching upward from last+1 modulo NUM_REQ.
REQ-019 On leaving IDLE, the FSM shall register grant, sr_data = req_data slice, and last = winner, then enter LOAD.
REQ-020 Strobe timing: each period is CLK_DIV cycles, counted by div_cnt from 0 to CLK_DIV-1; sr_shift = 1 when div_cnt >= CLK_DIV/2, else 0.
REQ-021 LOAD: sr_load = 1 for exactly one period, so the single rising sr_shift edge latches sr_data; the FSM then enters SHIFT.
REQ-022 SHIFT: sr_load = 0 for exactly BIT_LEN periods, producing BIT_LEN rising strobe edges; a bit counter runs from BIT_LEN-1 down to 0; the FSM then enters CHECK.
REQ-023 CHECK lasts one cycle: ack[winner] = 1; err = ~sr_complete; frame = 0; sr_shift = 0; the FSM then enters IDLE.
REQ-024 IDLE shall last at least one cycle between transfers, so the minimum transfer period is CLK_DIV*(BIT_LEN+1)+2 cycles.
REQ-025 grant and sr_data shall stay constant from LOAD entry through CHECK; grant shall clear on return to IDLE.
REQ-026 Deasserting req or changing req_data mid-transfer shall have no effect; the transfer completes and ack is still issued.
REQ-027 A requester holding req after its ack shall be eligible again only behind the other pending requesters (round-robin).
REQ-028 In IDLE, sr_load, sr_shift, frame and ack shall be 0.
REQ-029 With CLK_DIV = 4 and BIT_LEN = 8, ack shall rise 36 cycles after grant rises.

Reset
REQ-030 While reset_n = 0 at a clk edge: state = IDLE; grant, ack, err, busy, frame, sr_load, sr_shift = 0; sr_data = 0; last = NUM_REQ-1.
REQ-031 Reset asserted mid-transfer shall abort the transfer with no ack; the next transfer's LOAD period shall fully reload the shift register.

Verification
REQ-032 Single request: req = 0001, req_data[7:0] = 8'hA5 -> grant = 0001 and sr_data = A5 the next cycle; sr_load high for 4 cycles; 9 sr_shift rising edges; model sink serial output = 1,0,1,0,0,1,0,1; ack = 0001 and err = 0.
REQ-033 Contention: req = 1111 held continuously -> grant order 0001, 0010, 0100, 1000, 0001; consecutive grants 38 cycles apart.
REQ-034 Fairness: req = 0101 after a grant to 0 -> next grant goes to 2, not 0.
REQ-035 Fault: sr_complete tied 0 -> err = 1 coincident with ack; FSM returns to IDLE.
REQ-036 Withdrawal: req drops two cycles after grant -> transfer runs to completion; ack still pulses.
REQ-037 Reset mid-SHIFT (bit 4): the cycle after the reset edge, all outputs are 0 and there is no ack; a following req = 0010 is granted to requester 1.
